// File: rtl/sort_share_arbiter_if.sv
// Signal bundle between two requesters, the shared sorter and sort_share_arbiter.
// slave is the arbiter's view; master is the surrounding requester/sorter side.
interface sort_share_arbiter_if #(
   parameter int DATA_W = 8
);
   // requester side
   logic [1:0]        req;
   logic [1:0]        r_in_valid;
   logic [DATA_W-1:0] r_in_data0;
   logic [DATA_W-1:0] r_in_data1;
   logic [1:0]        gnt;
   logic [1:0]        out_valid;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        done;
   logic              err;
   logic              busy;
   // sorter side
   logic              s_in_valid;
   logic [DATA_W-1:0] s_in_data;
   logic              s_out_valid;
   logic [DATA_W-1:0] s_out_data;

   modport slave (
      input  req, r_in_valid, r_in_data0, r_in_data1, s_out_valid, s_out_data,
      output gnt, out_valid, out_data, done, err, busy, s_in_valid, s_in_data
   );

   modport master (
      output req, r_in_valid, r_in_data0, r_in_data1, s_out_valid, s_out_data,
      input  gnt, out_valid, out_data, done, err, busy, s_in_valid, s_in_data
   );
endinterface

// File: rtl/sort_share_arbiter.sv
// Round-robin share of one streaming sorter between two requesters: forwards the
// owner's burst, watchdogs the sort, and routes the sorted burst back to the owner.
module sort_share_arbiter #(
   parameter int DATA_W  = 8,
   parameter int MAX_N   = 256,
   parameter int TIMEOUT = 1300500
) (
   input  logic                clk,
   input  logic                rst,
   sort_share_arbiter_if.slave io_bus
);

   localparam int CNT_W  = $clog2(MAX_N + 1);
   localparam int WDOG_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_DRAIN
   } state_t;

   state_t            r_state,      w_state_nxt;
   logic              r_owner,      w_owner_nxt;
   logic              r_rr,         w_rr_nxt;
   logic [CNT_W-1:0]  r_n_items,    w_n_items_nxt;
   logic [CNT_W-1:0]  r_n_out,      w_n_out_nxt;
   logic [WDOG_W-1:0] r_wdog,       w_wdog_nxt;
   logic              r_ovf,        w_ovf_nxt;

   logic [1:0]        r_gnt,        w_gnt_nxt;
   logic [1:0]        r_out_valid,  w_out_valid_nxt;
   logic [DATA_W-1:0] r_out_data,   w_out_data_nxt;
   logic [1:0]        r_done,       w_done_nxt;
   logic              r_err,        w_err_nxt;
   logic              r_busy,       w_busy_nxt;
   logic              r_s_in_valid, w_s_in_valid_nxt;
   logic [DATA_W-1:0] r_s_in_data,  w_s_in_data_nxt;

   logic              w_pick;
   logic              w_own_valid;
   logic [DATA_W-1:0] w_own_data;
   logic              w_own_req;
   logic [1:0]        w_own_onehot;
   logic              w_job_end;

   // Preferred requester wins; otherwise the other one (only used when req != 0).
   assign w_pick       = io_bus.req[r_rr] ? r_rr : ~r_rr;
   assign w_own_valid  = io_bus.r_in_valid[r_owner];
   assign w_own_data   = r_owner ? io_bus.r_in_data1 : io_bus.r_in_data0;
   assign w_own_req    = io_bus.req[r_owner];
   assign w_own_onehot = {r_owner, ~r_owner};

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_owner_nxt      = r_owner;
      w_rr_nxt         = r_rr;
      w_n_items_nxt    = r_n_items;
      w_n_out_nxt      = r_n_out;
      w_wdog_nxt       = r_wdog;
      w_ovf_nxt        = r_ovf;
      w_gnt_nxt        = r_gnt;
      w_out_valid_nxt  = '0;
      w_out_data_nxt   = '0;
      w_done_nxt       = '0;
      w_err_nxt        = 1'b0;
      w_s_in_valid_nxt = 1'b0;
      w_s_in_data_nxt  = '0;
      w_job_end        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (io_bus.req != 2'b00) begin
               w_owner_nxt   = w_pick;
               w_gnt_nxt     = {w_pick, ~w_pick};
               w_n_items_nxt = '0;
               w_n_out_nxt   = '0;
               w_ovf_nxt     = 1'b0;
               w_state_nxt   = S_LOAD;
            end
         end

         S_LOAD: begin
            if (w_own_valid) begin
               // A full sorter drops further beats; the job still completes, flagged.
               if (r_n_items == CNT_W'(MAX_N)) begin
                  w_ovf_nxt = 1'b1;
               end else begin
                  w_s_in_valid_nxt = 1'b1;
                  w_s_in_data_nxt  = w_own_data;
                  w_n_items_nxt    = r_n_items + CNT_W'(1);
               end
            end else if (r_n_items != '0) begin
               w_wdog_nxt  = '0;
               w_state_nxt = S_WAIT;
            end else if (!w_own_req) begin
               w_err_nxt = 1'b1;
               w_job_end = 1'b1;
            end
         end

         S_WAIT: begin
            if (io_bus.s_out_valid) begin
               w_out_valid_nxt = w_own_onehot;
               w_out_data_nxt  = io_bus.s_out_data;
               w_n_out_nxt     = CNT_W'(1);
               if (r_n_items == CNT_W'(1)) begin
                  w_done_nxt = w_own_onehot;
                  w_err_nxt  = r_ovf;
                  w_job_end  = 1'b1;
               end else begin
                  w_state_nxt = S_DRAIN;
               end
            end else if (r_wdog == WDOG_W'(TIMEOUT - 1)) begin
               w_err_nxt = 1'b1;
               w_job_end = 1'b1;
            end else begin
               w_wdog_nxt = r_wdog + WDOG_W'(1);
            end
         end

         S_DRAIN: begin
            if (io_bus.s_out_valid) begin
               w_out_valid_nxt = w_own_onehot;
               w_out_data_nxt  = io_bus.s_out_data;
               w_n_out_nxt     = r_n_out + CNT_W'(1);
               if (r_n_out + CNT_W'(1) == r_n_items) begin
                  w_done_nxt = w_own_onehot;
                  w_err_nxt  = r_ovf;
                  w_job_end  = 1'b1;
               end
            end else begin
               // Short return: the owner is still released with done, but flagged.
               w_done_nxt = w_own_onehot;
               w_err_nxt  = 1'b1;
               w_job_end  = 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_job_end) begin
         w_state_nxt = S_IDLE;
         w_gnt_nxt   = 2'b00;
         w_rr_nxt    = ~r_owner;
      end

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_rr         <= 1'b0;
         r_n_items    <= '0;
         r_n_out      <= '0;
         r_wdog       <= '0;
         r_ovf        <= 1'b0;
         r_gnt        <= '0;
         r_out_valid  <= '0;
         r_out_data   <= '0;
         r_done       <= '0;
         r_err        <= 1'b0;
         r_busy       <= 1'b0;
         r_s_in_valid <= 1'b0;
         r_s_in_data  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_rr         <= w_rr_nxt;
         r_n_items    <= w_n_items_nxt;
         r_n_out      <= w_n_out_nxt;
         r_wdog       <= w_wdog_nxt;
         r_ovf        <= w_ovf_nxt;
         r_gnt        <= w_gnt_nxt;
         r_out_valid  <= w_out_valid_nxt;
         r_out_data   <= w_out_data_nxt;
         r_done       <= w_done_nxt;
         r_err        <= w_err_nxt;
         r_busy       <= w_busy_nxt;
         r_s_in_valid <= w_s_in_valid_nxt;
         r_s_in_data  <= w_s_in_data_nxt;
      end
   end

   assign io_bus.gnt        = r_gnt;
   assign io_bus.out_valid  = r_out_valid;
   assign io_bus.out_data   = r_out_data;
   assign io_bus.done       = r_done;
   assign io_bus.err        = r_err;
   assign io_bus.busy       = r_busy;
   assign io_bus.s_in_valid = r_s_in_valid;
   assign io_bus.s_in_data  = r_s_in_data;

endmodule

// File: tb/tb_sort_share_arbiter.sv
// Randomized scoreboard bench for sort_share_arbiter: the stimulus queues expected
// grants, sorter beats, returned beats and end events; a negedge monitor pops and compares.
module tb_sort_share_arbiter;

   localparam int DATA_W  = 8;
   localparam int MAX_N   = 256;
   localparam int TIMEOUT = 40;

   typedef struct packed {
      logic [1:0]        ov;
      logic [DATA_W-1:0] d;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sort_share_arbiter_if #(.DATA_W(DATA_W)) ifc ();

   sort_share_arbiter #(
      .DATA_W (DATA_W),
      .MAX_N  (MAX_N),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .io_bus(ifc)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [DATA_W-1:0] exp_sin[$];
   out_t              exp_out[$];
   logic [4:0]        exp_evt[$];   // {out_valid, done, err} at the job-end cycle
   logic [1:0]        exp_gnt[$];
   logic [DATA_W-1:0] sin_q[$];     // what the sorter has received this job
   logic [1:0]        prev_gnt = 2'b00;

   logic [1:0] req_v;    // requests currently held by the requesters
   int         rr_m;     // requester that wins a tie
   int         end_cyc;  // cycle of the latest job end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Sorter model input capture, sampled away from the active edge.
   always @(negedge clk) begin
      if (!rst && ifc.s_in_valid) sin_q.push_back(ifc.s_in_data);
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (ifc.s_in_valid) begin
         if (exp_sin.size() == 0) check("s_in_unexpected", ifc.s_in_valid, 1'b0);
         else                     check("s_in_data", ifc.s_in_data, exp_sin.pop_front());
      end
      if (ifc.out_valid != 2'b00) begin
         if (exp_out.size() == 0) check("out_unexpected", ifc.out_valid, 2'b00);
         else                     check("out_beat", {ifc.out_valid, ifc.out_data}, exp_out.pop_front());
      end
      if (ifc.done != 2'b00 || ifc.err) begin
         if (exp_evt.size() == 0) check("evt_unexpected", {ifc.done, ifc.err}, 3'b000);
         else                     check("job_end_evt", {ifc.out_valid, ifc.done, ifc.err}, exp_evt.pop_front());
      end
      if (ifc.gnt != 2'b00 && prev_gnt == 2'b00) begin
         if (exp_gnt.size() == 0) check("gnt_unexpected", ifc.gnt, 2'b00);
         else                     check("gnt", ifc.gnt, exp_gnt.pop_front());
      end
      prev_gnt <= ifc.gnt;
   end

   // One job: request, burst of n beats, sorter returns ret beats (or nothing when silent),
   // then `extra` stray sorter beats; rst_mid resets the block partway through the return.
   task automatic do_job(input logic [1:0] add_req, input int n, input int ret,
                         input bit silent, input int extra, input bit rst_mid);
      int w, cnt, k, wait_entry, dly, p, budget;
      bit carried, got;
      logic [DATA_W-1:0] d;
      logic [DATA_W-1:0] kept[$];
      logic [DATA_W-1:0] srt[$];
      logic [1:0] oh;

      carried = (req_v != 2'b00);
      req_v   = req_v | add_req;
      ifc.req = req_v;
      w  = req_v[rr_m] ? rr_m : 1 - rr_m;
      oh = (w == 0) ? 2'b01 : 2'b10;
      exp_gnt.push_back(oh);

      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         got = (ifc.gnt != 2'b00);
      end
      check("gnt_seen", got, 1'b1);
      if (!got) begin
         req_v = 2'b00; ifc.req = req_v;
         return;
      end
      if (carried) check("idle_gap", cyc - end_cyc, 1);
      sin_q.delete();

      if (n == 0) begin
         req_v[w] = 1'b0;
         ifc.req  = req_v;
         exp_evt.push_back({2'b00, 2'b00, 1'b1});
         k = 0;
      end else begin
         for (int i = 0; i < n; i++) begin
            d = DATA_W'($urandom);
            ifc.r_in_valid[w]     = 1'b1;
            ifc.r_in_valid[1 - w] = 1'($urandom_range(0, 1));
            if (w == 0) begin
               ifc.r_in_data0 = d; ifc.r_in_data1 = DATA_W'($urandom);
            end else begin
               ifc.r_in_data1 = d; ifc.r_in_data0 = DATA_W'($urandom);
            end
            if (i < MAX_N) begin
               kept.push_back(d);
               exp_sin.push_back(d);
            end
            @(posedge clk); #1;
         end
         ifc.r_in_valid = 2'b00;

         // Descending order by insertion.
         foreach (kept[i]) begin
            p = 0;
            while (p < srt.size() && srt[p] >= kept[i]) p++;
            srt.insert(p, kept[i]);
         end
         cnt = kept.size();
         k   = silent ? 0 : ((ret < cnt) ? ret : cnt);
         for (int i = 0; i < k; i++) exp_out.push_back({oh, srt[i]});
         exp_evt.push_back({(!silent && k == cnt) ? oh : 2'b00,
                            silent ? 2'b00 : oh,
                            silent || (n > MAX_N) || (k < cnt)});

         got = 1'b0;
         for (int i = 0; i < cnt + 8 && !got; i++) begin
            @(posedge clk); #1;
            got = (sin_q.size() == cnt);
         end
         check("sorter_fed", sin_q.size(), cnt);
         wait_entry = cyc;

         if (!silent) begin
            dly = $urandom_range(0, 3);
            repeat (dly) begin @(posedge clk); #1; end
            for (int i = 0; i < k; i++) begin
               ifc.s_out_valid = 1'b1;
               ifc.s_out_data  = srt[i];
               @(posedge clk); #1;
               if (rst_mid && i == 1) begin
                  #2;
                  check("busy_in_drain", ifc.busy, 1'b1);
                  rst = 1'b1;
                  #1;
                  check("rst_async", {ifc.gnt, ifc.out_valid, ifc.out_data, ifc.done, ifc.err,
                                      ifc.busy, ifc.s_in_valid, ifc.s_in_data}, '0);
                  exp_sin.delete(); exp_out.delete(); exp_evt.delete(); exp_gnt.delete();
                  ifc.s_out_valid = 1'b0;
                  req_v = 2'b00; ifc.req = req_v;
                  rr_m  = 0;
                  @(posedge clk); #1;
                  check("rst_held", {ifc.gnt, ifc.busy, ifc.out_valid}, '0);
                  rst = 1'b0;
                  return;
               end
            end
            ifc.s_out_valid = 1'b0;
            ifc.s_out_data  = DATA_W'($urandom);
         end
      end

      budget = TIMEOUT + 20;
      while (!(ifc.done != 2'b00 || ifc.err) && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      got = (ifc.done != 2'b00 || ifc.err);
      check("job_ended", got, 1'b1);
      if (silent) check("timeout_cycles", cyc - wait_entry, TIMEOUT);
      check("released", {ifc.gnt, ifc.busy}, 3'b000);
      end_cyc  = cyc;
      rr_m     = 1 - w;
      req_v[w] = 1'b0;
      ifc.req  = req_v;

      if (extra > 0 && req_v == 2'b00) begin
         for (int i = 0; i < extra; i++) begin
            ifc.s_out_valid = 1'b1;
            ifc.s_out_data  = DATA_W'($urandom);
            @(posedge clk); #1;
         end
         ifc.s_out_valid = 1'b0;
      end
   endtask

   initial begin
      logic [1:0] add;
      int n, ret;

      ifc.req = 2'b00; ifc.r_in_valid = 2'b00;
      ifc.r_in_data0 = '0; ifc.r_in_data1 = '0;
      ifc.s_out_valid = 1'b0; ifc.s_out_data = '0;
      req_v = 2'b00; rr_m = 0; end_cyc = 0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {ifc.gnt, ifc.out_valid, ifc.done, ifc.err, ifc.busy, ifc.s_in_valid}, '0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Simultaneous requests alternate, loser waits exactly one idle cycle.
      do_job(2'b11, 3, 3, 1'b0, 0, 1'b0);
      do_job(2'b00, 4, 4, 1'b0, 0, 1'b0);
      do_job(2'b11, 2, 2, 1'b0, 0, 1'b0);
      do_job(2'b00, 5, 5, 1'b0, 0, 1'b0);
      // Two-beat burst from requester 0.
      do_job(2'b01, 2, 2, 1'b0, 0, 1'b0);

      for (int j = 0; j < 14; j++) begin
         add = (req_v == 2'b00) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
         n   = $urandom_range(1, 10);
         ret = ($urandom_range(0, 4) == 0 && n > 1) ? n - 1 : n;
         do_job(add, n, ret, 1'b0, $urandom_range(0, 2), 1'b0);
      end
      if (req_v != 2'b00) do_job(2'b00, 3, 3, 1'b0, 0, 1'b0);

      do_job(2'b10, 0, 0, 1'b0, 0, 1'b0);          // request withdrawn before any beat
      do_job(2'b01, 256, 256, 1'b0, 0, 1'b0);      // exactly full
      do_job(2'b10, 257, 256, 1'b0, 0, 1'b0);      // one beat over
      do_job(2'b01, 4, 0, 1'b1, 0, 1'b0);          // sorter silent
      do_job(2'b10, 4, 3, 1'b0, 3, 1'b0);          // short return, then stray beats
      do_job(2'b01, 1, 1, 1'b0, 0, 1'b0);          // single item
      do_job(2'b10, 6, 6, 1'b0, 0, 1'b1);          // reset during return
      do_job(2'b11, 2, 2, 1'b0, 0, 1'b0);
      do_job(2'b00, 3, 3, 1'b0, 0, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      check("leftover_expected", exp_sin.size() + exp_out.size() + exp_evt.size() + exp_gnt.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
